line_window_3x3: RTL
====================

LINE_WINDOW_3X3 -- requirements
Module: line_window_3x3

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter MAX_WIDTH, default 224, maximum image row length in pixels; line-buffer depth.
REQ-003 SHALL have parameter MAX_HEIGHT, default 224, maximum image row count.
REQ-004 SHALL have port clock, input, 1, rising-edge clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port cfg_start, input, 1, one-cycle request to latch configuration and begin a frame.
REQ-007 SHALL have port cfg_width, input, $clog2(MAX_WIDTH+1), image width W.
REQ-008 SHALL have port cfg_height, input, $clog2(MAX_HEIGHT+1), image height H.
REQ-009 SHALL have port cfg_stride2, input, 1, 0 = stride 1, 1 = stride 2.
REQ-010 SHALL have port cfg_error, output, 1, one-cycle pulse on rejected configuration.
REQ-011 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-012 SHALL have port in_data, input, DATA_WIDTH, raster-order pixel.
REQ-013 SHALL have port in_valid, input, 1, in_data valid.
REQ-014 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-015 SHALL have port out_window, output, 9*DATA_WIDTH, window; element k = 3*i+j, i row (0 oldest), j column (0 leftmost).
REQ-016 SHALL have port out_valid, output, 1, out_window valid.
REQ-017 SHALL have port out_ready, input, 1, consumer accepts window.
REQ-018 SHALL have port out_last, output, 1, marks final window of frame, qualified by out_valid.
REQ-019 SHALL have port frame_done, output, 1, one-cycle pulse after last input pixel accepted.

Function
REQ-020 SHALL implement states IDLE and RUN; reset enters IDLE.
REQ-021 IDLE: cfg_start with 3<=W<=MAX_WIDTH, 3<=H<=MAX_HEIGHT latches W, H, stride, clears row/col counters, enters RUN next cycle.
REQ-022 IDLE: cfg_start with out-of-range W or H pulses cfg_error next cycle, stays IDLE.
REQ-023 cfg_start during RUN SHALL be ignored; latched configuration unchanged.
REQ-024 in_ready = (state==RUN) && (!out_valid || out_ready); in_ready low in IDLE.
REQ-025 Beat accepted iff in_valid && in_ready; only accepted beats advance line buffers, 3x3 register array, col/row counters.
REQ-026 Storage: two line buffers of MAX_WIDTH entries, effective length W; 3x3 shift array fed by current pixel and the two buffered rows at same column.
REQ-027 Col counter wraps W-1 -> 0, incrementing row; row counter stops at H-1.
REQ-028 Accepted pixel at (r,c) completes an eligible window iff r>=2, c>=2, and for stride 2 additionally (r-2) and (c-2) even.
REQ-029 Eligible window SHALL register to out_window/out_valid on the accepting edge (latency 1 cycle); window rows r-2..r, columns c-2..c.
REQ-030 out_valid and out_window SHALL hold stable until out_valid && out_ready; no window dropped or duplicated.
REQ-031 Simultaneous out handshake and new eligible beat SHALL load the new window with out_valid kept high.
REQ-032 out_last high with the window whose accepting pixel is (H-1,W-1), or last eligible one for stride 2.
REQ-033 Accepting pixel (H-1,W-1) SHALL pulse frame_done next cycle and return to IDLE; out_valid may remain pending in IDLE until consumed.
REQ-034 busy = (state==RUN).
REQ-035 Windows SHALL never span row boundaries; stale data from prior frames SHALL never appear in a valid window.

Reset
REQ-036 Reset at any time SHALL force IDLE, clear counters and latched configuration, and drive out_valid, out_last, in_ready, busy, cfg_error, frame_done to 0 and out_window to 0; line buffer contents need not clear.

Verification
REQ-037 W=4,H=4,stride1, pixels 0..15, out_ready=1 -> 4 windows; first {0,1,2,4,5,6,8,9,10}; last {5,6,7,9,10,11,13,14,15} with out_last=1; frame_done pulses once.
REQ-038 W=5,H=5,stride2, pixels 0..24 -> 4 windows; first {0,1,2,5,6,7,10,11,12}; second {2,3,4,7,8,9,12,13,14}; fourth with out_last=1.
REQ-039 W=4,H=4,stride1, out_ready low 5 cycles while out_valid -> out_window stable, in_ready=0, no data lost; all 4 windows delivered in order.
REQ-040 cfg_start W=2 -> cfg_error pulse 1 cycle, busy=0; W=MAX_WIDTH,H=3 -> MAX_WIDTH-2 windows.
REQ-041 Reset asserted mid-frame after 7 pixels -> all outputs 0 immediately; new frame W=4,H=4 yields REQ-037 windows exactly.
REQ-042 Random in_valid/out_ready gaps, W=7,H=6, both strides -> windows match golden model in count, order, content.

Source files
------------

// File: rtl/line_window_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream, built from two line buffers
// and a 3x3 shift array, with stride-1/stride-2 window selection and valid/ready flow control.
module line_window_3x3 #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_WIDTH  = 224,
   parameter int unsigned MAX_HEIGHT = 224
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            cfg_start,
   input  logic [$clog2(MAX_WIDTH+1)-1:0]  cfg_width,
   input  logic [$clog2(MAX_HEIGHT+1)-1:0] cfg_height,
   input  logic                            cfg_stride2,
   output logic                            cfg_error,
   output logic                            busy,
   input  logic [DATA_WIDTH-1:0]           in_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [9*DATA_WIDTH-1:0]         out_window,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            out_last,
   output logic                            frame_done
);

   localparam int unsigned WW = $clog2(MAX_WIDTH + 1);
   localparam int unsigned HW = $clog2(MAX_HEIGHT + 1);
   localparam int unsigned AW = $clog2(MAX_WIDTH);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                  state_q;
   logic [WW-1:0]           width_q, col_q, last_col_q;
   logic [HW-1:0]           height_q, row_q, last_row_q;
   logic                    stride2_q;
   logic [DATA_WIDTH-1:0]   win_q [9];
   logic [DATA_WIDTH-1:0]   win_d [9];
   logic [9*DATA_WIDTH-1:0] out_window_q, win_packed;
   logic                    out_valid_q, out_last_q, cfg_error_q, frame_done_q;

   // Row r-1 lives in lb0, row r-2 in lb1, both indexed by column.
   logic [DATA_WIDTH-1:0]   lb0_q [MAX_WIDTH];
   logic [DATA_WIDTH-1:0]   lb1_q [MAX_WIDTH];
   logic [DATA_WIDTH-1:0]   lb0_rd, lb1_rd;
   logic [AW-1:0]           col_idx;

   logic          accept, eligible, col_end, row_end, frame_end, is_last, cfg_ok;
   logic [WW-1:0] cfg_w_m1;
   logic [HW-1:0] cfg_h_m1;

   assign busy       = (state_q == StRun);
   assign in_ready   = (state_q == StRun) && (!out_valid_q || out_ready);
   assign out_window = out_window_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign cfg_error  = cfg_error_q;
   assign frame_done = frame_done_q;

   assign col_idx = col_q[AW-1:0];
   assign lb0_rd  = lb0_q[col_idx];
   assign lb1_rd  = lb1_q[col_idx];

   assign accept    = in_valid && in_ready;
   assign col_end   = (col_q == width_q - WW'(1));
   assign row_end   = (row_q == height_q - HW'(1));
   assign frame_end = col_end && row_end;
   assign is_last   = (col_q == last_col_q) && (row_q == last_row_q);
   // With stride 2 a window anchors on even (r-2),(c-2), i.e. even r and c.
   assign eligible  = (row_q >= HW'(2)) && (col_q >= WW'(2)) &&
                      (!stride2_q || (!row_q[0] && !col_q[0]));

   assign cfg_ok   = (cfg_width >= WW'(3)) && (cfg_width <= WW'(MAX_WIDTH)) &&
                     (cfg_height >= HW'(3)) && (cfg_height <= HW'(MAX_HEIGHT));
   assign cfg_w_m1 = cfg_width - WW'(1);
   assign cfg_h_m1 = cfg_height - HW'(1);

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         win_d[3*i]   = win_q[3*i+1];
         win_d[3*i+1] = win_q[3*i+2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = in_data;
      win_packed = '0;
      for (int k = 0; k < 9; k++) begin
         win_packed[k*DATA_WIDTH +: DATA_WIDTH] = win_d[k];
      end
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         lb1_q[col_idx] <= lb0_rd;
         lb0_q[col_idx] <= in_data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         width_q      <= '0;
         height_q     <= '0;
         stride2_q    <= 1'b0;
         last_col_q   <= '0;
         last_row_q   <= '0;
         col_q        <= '0;
         row_q        <= '0;
         out_window_q <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         cfg_error_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int k = 0; k < 9; k++) begin
            win_q[k] <= '0;
         end
      end else begin
         cfg_error_q  <= 1'b0;
         frame_done_q <= 1'b0;
         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (cfg_start) begin
                  if (cfg_ok) begin
                     width_q    <= cfg_width;
                     height_q   <= cfg_height;
                     stride2_q  <= cfg_stride2;
                     last_col_q <= cfg_stride2 ? (cfg_w_m1 & ~WW'(1)) : cfg_w_m1;
                     last_row_q <= cfg_stride2 ? (cfg_h_m1 & ~HW'(1)) : cfg_h_m1;
                     col_q      <= '0;
                     row_q      <= '0;
                     state_q    <= StRun;
                  end else begin
                     cfg_error_q <= 1'b1;
                  end
               end
            end
            StRun: begin
               if (accept) begin
                  win_q <= win_d;
                  if (eligible) begin
                     out_valid_q  <= 1'b1;
                     out_last_q   <= is_last;
                     out_window_q <= win_packed;
                  end
                  if (col_end) begin
                     col_q <= '0;
                     if (!row_end) begin
                        row_q <= row_q + HW'(1);
                     end
                  end else begin
                     col_q <= col_q + WW'(1);
                  end
                  if (frame_end) begin
                     state_q      <= StIdle;
                     frame_done_q <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
